fifo_uart_tx: RTL and testbench

Byte-serializing UART transmitter that drains the 16x8 synchronous FIFO directly downstream of it. Watches the FIFO empty flag, pops one byte per frame using the FIFO's show-ahead read data, and shifts it out LSB-first as 8N1 (optionally 8E1) on a single serial line. Sole consumer of the FIFO read port; sits between the FIFO and the chip-level TX pad.

---
 rtl/fifo_uart_tx.sv | 138 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead FIFO: one byte per frame, LSB first, 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bidx, bidx_n;
  logic [7:0]  shift, shift_n;
  logic        tx_n, done_n;
  logic        last;
`ifdef UART_TX_PARITY_EN
  logic        par, par_n;
`endif

  assign last    = (cnt == LAST);
  // Gated by rst so the pop strobe drops the instant reset asserts.
  assign fifo_rd = rst && (state == IDLE) && en && !fifo_empty;
  assign busy    = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    shift_n = shift;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        if (fifo_rd) begin
          shift_n = fifo_data;
          cnt_n   = '0;
          bidx_n  = '0;
          state_n = START;
`ifdef UART_TX_PARITY_EN
          par_n   = ^fifo_data;
`endif
        end
      end
      START: begin
        if (last) begin
          cnt_n   = '0;
          state_n = DATA;
        end else cnt_n = cnt + 16'd1;
      end
      DATA: begin
        if (last) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          bidx_n  = bidx + 3'd1;
          if (bidx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else cnt_n = cnt + 16'd1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (last) begin
          cnt_n   = '0;
          state_n = STOP;
        end else cnt_n = cnt + 16'd1;
      end
`endif
      STOP: begin
        if (last) begin
          cnt_n   = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end else cnt_n = cnt + 16'd1;
      end
      default: state_n = IDLE;
    endcase

    // tx is registered from the next state so the line never glitches.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bidx    <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bidx    <= bidx_n;
      shift   <= shift_n;
      tx      <= tx_n;
      tx_done <= done_n;
`ifdef UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural show-ahead FIFO, serial decoder, byte scoreboard.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [7:0] fmem [0:63];
  logic [7:0] exp_q [$];
  int         pop_cyc [$];
  logic       done_d = 1'b0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fmem[rd_ptr[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd === 1'b1) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge clk) begin
    if (fifo_rd === 1'b1) begin
      pop_cyc.push_back(cyc);
      pop_cnt = pop_cnt + 1;
      if (fifo_empty || busy) begin
        failures = failures + 1;
        $display("FAIL rd_guard: fifo_rd=1 with fifo_empty=%b busy=%b, required no pop", fifo_empty, busy);
      end
    end
    if (tx_done === 1'b1 && done_d === 1'b1) begin
      failures = failures + 1;
      $display("FAIL done_width: tx_done high 2 cycles, required 1-cycle pulse");
    end
    done_d <= tx_done;
  end

  task automatic push(input logic [7:0] d);
    fmem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task automatic drive_slot();
    @(posedge clk); #1;
  endtask

  // Decode one frame, checking every bit period is exactly CPB cycles wide.
  task automatic recv_frame(input string nm, output int st);
    int t;
    logic [7:0] b;
    logic p;
    logic bad;
    logic [7:0] e;
    st = -1; bad = 1'b0; b = '0; p = 1'b0;
    t = 0;
    @(negedge clk);
    while (tx !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL %s_start: tx stayed %b for 2000 cycles, required start bit", nm, tx);
      return;
    end
    st = cyc;
    checks++;
    if (pop_cyc.size() == 0 || st != pop_cyc[0] + 1) begin
      failures++;
      $display("FAIL %s_latency: tx fell at cycle %0d, required pop cycle+1 (%0d)", nm, st,
               pop_cyc.size() ? pop_cyc[0] + 1 : -1);
    end
    if (pop_cyc.size() > 0) void'(pop_cyc.pop_front());
    if (busy !== 1'b1) bad = 1'b1;
    for (int j = 1; j < CPB; j++) begin
      @(negedge clk);
      if (tx !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        if (j == 0) b[i] = tx;
        else if (tx !== b[i]) bad = 1'b1;
        if (busy !== 1'b1) bad = 1'b1;
      end
    end
`ifdef UART_TX_PARITY_EN
    for (int j = 0; j < CPB; j++) begin
      @(negedge clk);
      if (j == 0) p = tx;
      else if (tx !== p) bad = 1'b1;
      if (busy !== 1'b1) bad = 1'b1;
    end
`endif
    for (int j = 0; j < CPB; j++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s_shape: bit periods not %0d cycles or busy dropped, byte seen %h", nm, CPB, b);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b1 || busy !== 1'b0 || cyc - st != FRAME) begin
      failures++;
      $display("FAIL %s_done: tx_done=%b busy=%b at +%0d, required 1/0 at +%0d", nm, tx_done, busy,
               cyc - st, FRAME);
    end
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    checks++;
    if (b !== e) begin
      failures++;
      $display("FAIL %s_data: got %h, required %h", nm, b, e);
    end
`ifdef UART_TX_PARITY_EN
    checks++;
    if (p !== ^e) begin
      failures++;
      $display("FAIL %s_parity: got %b, required %b", nm, p, ^e);
    end
`endif
  endtask

  task automatic wait_pop(input int base);
    int t = 0;
    while (pop_cnt == base && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (pop_cnt == base) begin
      failures++;
      $display("FAIL wait_pop: no fifo_rd within 2000 cycles, required a pop");
    end
  endtask

  task automatic test_reset();
    int st;
    rst = 1'b0; en = 1'b1;
    push(8'h3C);
    repeat (5) drive_slot();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0 || tx_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals: tx=%b busy=%b fifo_rd=%b tx_done=%b, required 1/0/0/0",
               tx, busy, fifo_rd, tx_done);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (fifo_rd !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_rd: fifo_rd=%b, required 1", fifo_rd);
    end
    recv_frame("reset_byte", st);
  endtask

  task automatic test_single();
    int st;
    drive_slot();
    push(8'hA5);
    recv_frame("single_a5", st);
  endtask

  task automatic test_back_to_back();
    int s0, s1, s2, base;
    drive_slot();
    base = pop_cnt;
    push(8'h01); push(8'h80); push(8'hFF);
    recv_frame("b2b_01", s0);
    recv_frame("b2b_80", s1);
    recv_frame("b2b_ff", s2);
    checks++;
    if (s1 - s0 != FRAME + 1 || s2 - s1 != FRAME + 1) begin
      failures++;
      $display("FAIL b2b_spacing: %0d,%0d, required %0d", s1 - s0, s2 - s1, FRAME + 1);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (pop_cnt != base + 3 || fifo_empty !== 1'b1 || tx !== 1'b1) begin
      failures++;
      $display("FAIL b2b_drain: pops=%0d empty=%b tx=%b, required 3/1/1", pop_cnt - base, fifo_empty, tx);
    end
  endtask

  task automatic test_enable();
    int st, base;
    drive_slot();
    en = 1'b0;
    base = pop_cnt;
    push(8'h5A);
    repeat (20) @(negedge clk);
    checks++;
    if (pop_cnt != base || tx !== 1'b1) begin
      failures++;
      $display("FAIL en_off: pops=%0d tx=%b, required 0/1", pop_cnt - base, tx);
    end
    drive_slot();
    en = 1'b1;
    fork
      recv_frame("en_drop", st);
      begin
        wait_pop(base);
        repeat (12) drive_slot();
        en = 1'b0;
        push(8'h96);
      end
    join
    repeat (60) @(negedge clk);
    checks++;
    if (pop_cnt != base + 1 || tx !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL en_hold: pops=%0d tx=%b busy=%b, required 1/1/0", pop_cnt - base, tx, busy);
    end
    drive_slot();
    en = 1'b1;
    recv_frame("en_resume", st);
  endtask

  task automatic test_reset_mid();
    int st, base;
    drive_slot();
    base = pop_cnt;
    push(8'hC3); push(8'h69);
    wait_pop(base);
    repeat (18) drive_slot();
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: tx=%b busy=%b in bit 3 of C3, required 0/1", tx, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) begin
      failures++;
      $display("FAIL mid_async: tx=%b busy=%b fifo_rd=%b, required 1/0/0", tx, busy, fifo_rd);
    end
    void'(exp_q.pop_front());
    if (pop_cyc.size() > 0) void'(pop_cyc.pop_front());
    repeat (3) drive_slot();
    rst = 1'b1;
    recv_frame("mid_fresh", st);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int s0, s1;
    drive_slot();
    push(8'h07); push(8'h03);
    recv_frame("par_07", s0);
    recv_frame("par_03", s1);
    checks++;
    if (s1 - s0 != 45) begin
      failures++;
      $display("FAIL par_spacing: %0d, required 45", s1 - s0);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
